row_assembler: RTL and testbench
================================

Name: row_assembler

Overview:
- Upstream feeder of the row compressor. Accepts a serial word stream over a valid/ready handshake and packs it into rows of up to MAX_R_SIZE words.
- Ping-pong double-buffers completed rows and presents each full row with a valid/ready handshake. The row_valid & row_ready transfer is the compressor's enable_in strobe.
- Sustains one input word per cycle while the downstream keeps up.

Parameters:
- WORD_WIDTH, 8, width of one data word.
- MAX_R_SIZE, 4, maximum words per row; lane count of row_data.
- R_DIST_WIDTH, 2, log2(MAX_R_SIZE); lane index width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- r_size  in  R_DIST_WIDTH+1  configured row length; sampled on the first word of each row
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WORD_WIDTH  input word
- in_last  in  1  final word of a row; closes a short row early
- row_valid  out  1  a completed row is presented
- row_ready  in  1  downstream consumes the row
- row_data  out  WORD_WIDTH*MAX_R_SIZE  row; word k in bits [WORD_WIDTH*k +: WORD_WIDTH]
- row_len  out  R_DIST_WIDTH+1  number of valid words in the row (1..MAX_R_SIZE)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values:
  - Both slots empty; wr_sel=0, rd_sel=0, word count=0.
  - Slot data and lengths are 0.
  - row_valid=0, row_data=0, row_len=0, in_ready=1.
- Storage: two slots, each holding a data vector, a length and a full flag.
  - wr_sel points at the slot being filled; rd_sel points at the slot being presented.
- Input handshake:
  - in_ready = !full[wr_sel] (combinational from registers).
  - A word is accepted when in_valid & in_ready.
- Row start (count==0, word accepted):
  - Latch the effective size: r_size if 1..MAX_R_SIZE, otherwise MAX_R_SIZE (0 and out-of-range map to MAX).
  - Write the word to lane 0 and clear lanes 1..MAX_R_SIZE-1 to zero in the same cycle.
- Subsequent words go to lane count. count increments per accepted word.
- Row close: on the accepted word where count+1 == latched size, or in_last=1 on that word.
  - Set full[wr_sel], set len = count+1, toggle wr_sel, reset count to 0.
  - Unfilled lanes stay zero.
  - An in_last word arriving with count+1 < size gives a short row; in_last on the size-th word is an ordinary close.
- Output:
  - row_valid = full[rd_sel].
  - row_data and row_len are the rd_sel slot contents, stable while row_valid & !row_ready.
  - On row_valid & row_ready: clear full[rd_sel], toggle rd_sel.
  - row_data is forced to 0 while row_valid=0.
- Latency: row_valid rises the cycle after the closing word is accepted.
- Simultaneous close and drain: these always hit different slots (close needs !full, drain needs full). Both take effect in the same cycle.
- Both slots full: in_ready=0 and the word stream stalls.
  - A drain in cycle N raises in_ready in cycle N+1; there is no combinational ready path from row_ready to in_ready.
- r_size changes mid-row are ignored until the next row start.
- Reset asserted mid-row or mid-handshake: all state clears immediately and any partial or pending rows are discarded.

Decomposition:
- Shared package holds:
  - localparams LANE_W = WORD_WIDTH and ROW_W = WORD_WIDTH*MAX_R_SIZE;
  - the effective-size clamp function;
  - the lane-slice helper.
- One sub-module, row_slot: a single slot's data, length and full flag, with write-lane, clear and drain controls. Instantiated twice.
- Top level holds count, wr_sel, rd_sel and the handshakes.

Test Plan:
- Stream 8 words 0x01..0x08, r_size=4, row_ready=1 -> two rows, row_data=0x04030201 then 0x08070605, row_len=4. Each row_valid appears one cycle after its 4th word.
- r_size=4, words 0x11,0x22 with in_last on 0x22 -> row_data=0x00002211, row_len=2. The next row starts at lane 0.
- row_ready=0, stream 12 words with r_size=4 -> in_ready drops after word 8 with both slots full. Raising row_ready for one cycle gives 0x04030201 and re-raises in_ready the following cycle.
- r_size=0 and then r_size=7 -> both treated as 4. Also, changing r_size from 4 to 2 after the first word of a row still yields row_len=4 for that row.
- Assert reset_n low with one slot full and a half-filled row -> row_valid=0, row_data=0 and in_ready=1 immediately. The first row after reset starts at lane 0.

Source files
------------

// File: rtl/row_assembler_pkg.sv
// Shared configuration and helpers for the row assembler.
// The word width and row geometry are fixed here. Every file of the
// block imports them, so this package is the single place to retune it.
package row_assembler_pkg;

   localparam int WORD_WIDTH   = 8;
   localparam int MAX_R_SIZE   = 4;
   localparam int R_DIST_WIDTH = 2;

   localparam int LANE_W = WORD_WIDTH;
   localparam int ROW_W  = WORD_WIDTH * MAX_R_SIZE;
   // Holds a length of 0..MAX_R_SIZE inclusive.
   localparam int CNT_W  = R_DIST_WIDTH + 1;

   // A configured row length of 0 or above MAX_R_SIZE means "full row".
   function automatic logic [CNT_W-1:0] eff_size(input logic [CNT_W-1:0] r);
      if (r == '0 || r > CNT_W'(MAX_R_SIZE))
         eff_size = CNT_W'(MAX_R_SIZE);
      else
         eff_size = r;
   endfunction

   // Lowest bit of lane k inside a packed row.
   function automatic int lane_lo(input int k);
      return k * LANE_W;
   endfunction

endpackage

// File: rtl/row_assembler_row_slot.sv
// One ping-pong slot. It holds a row's data, its length and a full flag.
// A write with start set loads lane 0 and zeroes the other lanes, so a
// short row never exposes words left over from an earlier row.
module row_slot
   import row_assembler_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    wr_en,
   input  logic                    start,
   input  logic [R_DIST_WIDTH-1:0] wr_lane,
   input  logic [LANE_W-1:0]       wr_data,
   input  logic                    close,
   input  logic [CNT_W-1:0]        close_len,
   input  logic                    drain,
   output logic                    full,
   output logic [ROW_W-1:0]        data,
   output logic [CNT_W-1:0]        len
);

   // Lane storage: a row start loads lane 0 and clears the rest; later words write their own lane.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data <= '0;
      end else if (wr_en) begin
         if (start)
            data <= ROW_W'(wr_data);
         else
            data[lane_lo(int'(wr_lane)) +: LANE_W] <= wr_data;
      end
   end

   // Full flag and length. close and drain never target the same slot in one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full <= 1'b0;
         len  <= '0;
      end else if (close) begin
         full <= 1'b1;
         len  <= close_len;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/row_assembler.sv
// Packs a serial word stream into rows and double-buffers the finished rows.
// Handshakes: a word moves when in_valid & in_ready, and a row moves when
// row_valid & row_ready. Neither ready depends combinationally on the
// other side, so a drain frees input space only on the following cycle.
module row_assembler
   import row_assembler_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [R_DIST_WIDTH:0]   r_size,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WORD_WIDTH-1:0]   in_data,
   input  logic                    in_last,
   output logic                    row_valid,
   input  logic                    row_ready,
   output logic [ROW_W-1:0]        row_data,
   output logic [R_DIST_WIDTH:0]   row_len
);

   logic [1:0]              slot_full;
   logic [ROW_W-1:0]        slot_data [2];
   logic [CNT_W-1:0]        slot_len  [2];

   logic                    wr_sel;
   logic                    rd_sel;
   logic [R_DIST_WIDTH-1:0] count;
   logic [CNT_W-1:0]        size_q;

   logic                    accept;
   logic                    row_start;
   logic [CNT_W-1:0]        cur_size;
   logic [CNT_W-1:0]        cnt_next;
   logic                    close_row;
   logic                    drain;

   // Handshake decode and row-close detection. A row's size is fixed at its first word.
   always_comb begin
      in_ready  = !slot_full[wr_sel];
      row_valid = slot_full[rd_sel];
      accept    = in_valid & in_ready;
      drain     = row_valid & row_ready;
      row_start = (count == '0);
      cur_size  = row_start ? eff_size(r_size) : size_q;
      cnt_next  = CNT_W'(count) + CNT_W'(1);
      close_row = accept & ((cnt_next == cur_size) | in_last);
      row_data  = row_valid ? slot_data[rd_sel] : '0;
      row_len   = slot_len[rd_sel];
   end

   for (genvar i = 0; i < 2; i++) begin : g_slot
      row_slot u_slot (
         .clk       (clk),
         .reset_n   (reset_n),
         .wr_en     (accept & (wr_sel == 1'(i))),
         .start     (row_start),
         .wr_lane   (count),
         .wr_data   (in_data),
         .close     (close_row & (wr_sel == 1'(i))),
         .close_len (cnt_next),
         .drain     (drain & (rd_sel == 1'(i))),
         .full      (slot_full[i]),
         .data      (slot_data[i]),
         .len       (slot_len[i])
      );
   end

   // Fill-side state: word count, latched row size and the slot being filled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count  <= '0;
         size_q <= '0;
         wr_sel <= 1'b0;
      end else if (accept) begin
         if (row_start)
            size_q <= eff_size(r_size);
         if (close_row) begin
            count  <= '0;
            wr_sel <= ~wr_sel;
         end else begin
            count  <= count + 1'b1;
         end
      end
   end

   // Drain-side state: move to the other slot after each consumed row.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rd_sel <= 1'b0;
      else if (drain)
         rd_sel <= ~rd_sel;
   end

endmodule

// File: tb/tb_row_assembler.sv
// Directed bench for row_assembler. A row-level model builds each expected
// row from the accepted words and queues it. A monitor checks handshake
// levels on every cycle and checks each consumed row against that queue.
module tb_row_assembler;
   import row_assembler_pkg::*;

   localparam int W = CNT_W + ROW_W;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [R_DIST_WIDTH:0] r_size;
   logic                  in_valid;
   logic                  in_ready;
   logic [WORD_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  row_valid;
   logic                  row_ready;
   logic [ROW_W-1:0]      row_data;
   logic [R_DIST_WIDTH:0] row_len;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0]     exp_q [$];
   logic [W-1:0]     got_q [$];
   logic [7:0]       part [MAX_R_SIZE];
   int               pcount = 0;
   int               psize  = MAX_R_SIZE;
   logic [ROW_W-1:0] mrow;

   always #5 clk = ~clk;

   row_assembler dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .r_size    (r_size),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_data  (row_data),
      .row_len   (row_len)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor and model. It samples at the falling edge and applies the transfers of the coming rising edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         pcount = 0;
      end else begin
         check("row_valid", row_valid, 64'(exp_q.size() > 0));
         check("in_ready", in_ready, 64'(exp_q.size() < 2));
         if (!row_valid)
            check("row_data_idle", row_data, 64'd0);
         if (row_valid && row_ready) begin
            got_q.push_back({row_len, row_data});
            if (exp_q.size() == 0)
               check("row_unexpected", 64'({row_len, row_data}), 64'hDEAD_BEEF_0);
            else
               check("row", 64'({row_len, row_data}), 64'(exp_q.pop_front()));
         end
         if (in_valid && in_ready) begin
            if (pcount == 0) begin
               psize = (r_size >= 1 && int'(r_size) <= MAX_R_SIZE) ? int'(r_size) : MAX_R_SIZE;
               for (int k = 0; k < MAX_R_SIZE; k++) part[k] = 8'h00;
            end
            part[pcount] = in_data;
            pcount++;
            if (pcount == psize || in_last) begin
               mrow = '0;
               for (int k = 0; k < MAX_R_SIZE; k++) mrow[k*8 +: 8] = part[k];
               exp_q.push_back({CNT_W'(pcount), mrow});
               pcount = 0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic last);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: word %h not accepted, expected accept within 50 cycles", d);
      end
   endtask

   task automatic drain_wait();
      bit idle;
      idle      = 1'b0;
      row_ready = 1'b1;
      for (int t = 0; t < 20 && !idle; t++) begin
         @(negedge clk);
         if (!row_valid) idle = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!idle) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: row_valid still 1, expected 0 within 20 cycles");
      end
   endtask

   task automatic expect_row(input string name, input logic [31:0] d, input int len);
      if (got_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: no row consumed, expected data %h len %0d", name, d, len);
      end else begin
         check(name, 64'(got_q.pop_front()), 64'({CNT_W'(len), ROW_W'(d)}));
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      r_size    = 3'd4;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      row_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_row_valid", row_valid, 64'd0);
      check("rst_row_data", row_data, 64'd0);
      check("rst_row_len", row_len, 64'd0);
      check("rst_in_ready", in_ready, 64'd1);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Two full rows at full rate; the first row appears one cycle after its 4th word.
      row_ready = 1'b1;
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
      @(negedge clk);
      check("lat_pre", row_valid, 64'd0);
      @(posedge clk); #1;
      send(8'h04, 1'b0);
      @(negedge clk);
      check("lat_post", row_valid, 64'd1);
      @(posedge clk); #1;
      for (int i = 5; i <= 8; i++) send(8'(i), 1'b0);
      drain_wait();
      expect_row("t1_row0", 32'h04030201, 4);
      expect_row("t1_row1", 32'h08070605, 4);

      // Short row closed by in_last, then a normal row that must start at lane 0.
      send(8'h11, 1'b0); send(8'h22, 1'b1);
      send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0);
      drain_wait();
      expect_row("t2_short", 32'h00002211, 2);
      expect_row("t2_next", 32'h66554433, 4);

      // Back-pressure: both slots fill and a single drain frees input space one cycle later.
      row_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      @(negedge clk);
      check("t3_stall", in_ready, 64'd0);
      check("t3_head", row_data, 64'h04030201);
      @(posedge clk); #1;
      row_ready = 1'b1;
      @(negedge clk);
      check("t3_no_comb_ready", in_ready, 64'd0);
      @(posedge clk); #1;
      row_ready = 1'b0;
      @(negedge clk);
      check("t3_ready_back", in_ready, 64'd1);
      check("t3_second", row_data, 64'h08070605);
      @(posedge clk); #1;
      expect_row("t3_row0", 32'h04030201, 4);
      for (int i = 9; i <= 12; i++) send(8'(i), 1'b0);
      drain_wait();
      expect_row("t3_row1", 32'h08070605, 4);
      expect_row("t3_row2", 32'h0C0B0A09, 4);

      // r_size 0 and 7 both act as 4; a size change in mid-row has no effect until the next row.
      r_size = 3'd0;
      for (int i = 1; i <= 4; i++) send(8'(8'h20 + i), 1'b0);
      r_size = 3'd7;
      for (int i = 1; i <= 4; i++) send(8'(8'h30 + i), 1'b0);
      r_size = 3'd4;
      send(8'h41, 1'b0);
      r_size = 3'd2;
      send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b0);
      drain_wait();
      expect_row("t4_size0", 32'h24232221, 4);
      expect_row("t4_size7", 32'h34333231, 4);
      expect_row("t4_midchg", 32'h44434241, 4);
      r_size = 3'd4;

      // Reset with one full slot and a half-built row.
      row_ready = 1'b0;
      for (int i = 1; i <= 6; i++) send(8'(8'h50 + i), 1'b0);
      reset_n = 1'b0;
      #1;
      check("t5_row_valid", row_valid, 64'd0);
      check("t5_row_data", row_data, 64'd0);
      check("t5_in_ready", in_ready, 64'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      send(8'hA1, 1'b0); send(8'hA2, 1'b1);
      drain_wait();
      expect_row("t5_after", 32'h0000A2A1, 2);

      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
